dispense_timer: RTL and testbench

DISPENSE_TIMER -- requirements
Module: dispense_timer

---
 rtl/dispense_pkg.sv | 30 +++
 rtl/dispense_recipe_rom.sv | 50 +++++
 rtl/dispense_timer.sv | 140 ++++++++++++++
 tb/tb_dispense_timer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_pkg.sv
// dispense_pkg: shared constants for the drink dispense timer.
// Holds ingredient codes, coffee-type codes, the timer state encoding,
// the default duration width and the prescaler width helper.
package dispense_pkg;

  localparam int DUR_W = 4;

  localparam logic [2:0] ING_AGUA  = 3'd1;
  localparam logic [2:0] ING_CAFE  = 3'd2;
  localparam logic [2:0] ING_MILK  = 3'd3;
  localparam logic [2:0] ING_CHOCO = 3'd4;
  localparam logic [2:0] ING_AZUC  = 3'd5;

  localparam logic [2:0] CTYPE_1 = 3'd1;
  localparam logic [2:0] CTYPE_2 = 3'd2;
  localparam logic [2:0] CTYPE_3 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bits needed to count 0..presc-1; a one-cycle tick still gets one bit.
  function automatic int preCntWidth(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage

// File: rtl/dispense_recipe_rom.sv
// dispense_recipe_rom: combinational recipe table mapping a coffee type and
// an ingredient code to a dispense duration in prescaler ticks. Invalid
// ingredient codes return 0; unknown coffee types use one tick everywhere.
module dispense_recipe_rom #(
  parameter int DUR_W = dispense_pkg::DUR_W
) (
  input  logic [2:0]       c_type_i,
  input  logic [2:0]       ing_type_i,
  output logic [DUR_W-1:0] d_o
);
  import dispense_pkg::*;

  // Table lookup: column chosen by coffee type, row by ingredient.
  always_comb begin
    d_o = '0;
    if (ing_type_i >= ING_AGUA && ing_type_i <= ING_AZUC) begin
      case (c_type_i)
        CTYPE_1: begin
          case (ing_type_i)
            ING_AGUA:  d_o = DUR_W'(3);
            ING_CAFE:  d_o = DUR_W'(4);
            ING_MILK:  d_o = DUR_W'(0);
            ING_CHOCO: d_o = DUR_W'(0);
            default:   d_o = DUR_W'(1);
          endcase
        end
        CTYPE_2: begin
          case (ing_type_i)
            ING_AGUA:  d_o = DUR_W'(2);
            ING_CAFE:  d_o = DUR_W'(2);
            ING_MILK:  d_o = DUR_W'(5);
            ING_CHOCO: d_o = DUR_W'(0);
            default:   d_o = DUR_W'(1);
          endcase
        end
        CTYPE_3: begin
          case (ing_type_i)
            ING_AGUA:  d_o = DUR_W'(2);
            ING_CAFE:  d_o = DUR_W'(2);
            ING_MILK:  d_o = DUR_W'(3);
            ING_CHOCO: d_o = DUR_W'(3);
            default:   d_o = DUR_W'(2);
          endcase
        end
        default: d_o = DUR_W'(1);
      endcase
    end
  end

endmodule

// File: rtl/dispense_timer.sv
// dispense_timer: times one ingredient dispense phase for the brew sequencer.
// A request (start_timer high) latches the ingredient and coffee codes,
// looks up the duration, counts it down in prescaled ticks and emits a
// single t_expired pulse. Dropping start_timer early aborts silently.
// Optional build macro DISPENSE_ZERO_SKIP_EN: a zero duration finishes
// right after LOAD instead of being stretched to one full tick.
module dispense_timer #(
  parameter int PRESCALE = 50000000,
  parameter int DUR_W    = dispense_pkg::DUR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [2:0]       ing_type,
  input  logic [2:0]       c_type,
  output logic             t_expired,
  output logic             busy,
  output logic [DUR_W-1:0] remaining
);
  import dispense_pkg::*;

  localparam int PRE_W = preCntWidth(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] preCnt_q, preCnt_d;
  logic [DUR_W-1:0] remain_q, remain_d;
  logic [2:0]       ingType_q, ingType_d;
  logic [2:0]       cType_q, cType_d;
  logic             expired_q, expired_d;
  logic [DUR_W-1:0] romD;
  logic [DUR_W-1:0] loadD;

  dispense_recipe_rom #(
    .DUR_W(DUR_W)
  ) u_rom (
    .c_type_i  (cType_q),
    .ing_type_i(ing_type_q_unused_guard()),
    .d_o       (romD)
  );

  function automatic logic [2:0] ing_type_q_unused_guard();
    return ingType_q;
  endfunction

  // Zero-length durations either finish immediately or count one tick.
  always_comb begin
`ifdef DISPENSE_ZERO_SKIP_EN
    loadD = romD;
`else
    loadD = (romD == '0) ? DUR_W'(1) : romD;
`endif
  end

  // State, prescaler, countdown and latched codes, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      preCnt_q  <= '0;
      remain_q  <= '0;
      ingType_q <= '0;
      cType_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      preCnt_q  <= preCnt_d;
      remain_q  <= remain_d;
      ingType_q <= ingType_d;
      cType_q   <= cType_d;
      expired_q <= expired_d;
    end
  end

  // Sequencing: capture codes on request, load the duration, tick it down,
  // pulse once on completion, and abort whenever the request is withdrawn.
  always_comb begin
    state_d   = state_q;
    preCnt_d  = preCnt_q;
    remain_d  = remain_q;
    ingType_d = ingType_q;
    cType_d   = cType_q;
    expired_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        preCnt_d = '0;
        remain_d = '0;
        if (start_timer) begin
          state_d   = ST_LOAD;
          ingType_d = ing_type;
          cType_d   = c_type;
        end
      end
      ST_LOAD: begin
        preCnt_d = '0;
        if (!start_timer) begin
          state_d  = ST_IDLE;
          remain_d = '0;
        end else begin
          state_d  = ST_RUN;
          remain_d = loadD;
        end
      end
      ST_RUN: begin
        if (!start_timer) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          preCnt_d = '0;
        end else if (remain_q == '0) begin
          state_d   = ST_DONE;
          expired_d = 1'b1;
          preCnt_d  = '0;
        end else if (preCnt_q == PRE_LAST) begin
          preCnt_d = '0;
          remain_d = remain_q - DUR_W'(1);
        end else begin
          preCnt_d = preCnt_q + PRE_W'(1);
        end
      end
      ST_DONE: begin
        remain_d = '0;
        if (!start_timer) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        preCnt_d = '0;
        remain_d = '0;
      end
    endcase
  end

  // Outputs decode directly from registered state so reset clears them at once.
  always_comb begin
    t_expired = expired_q;
    busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
    remaining = (state_q == ST_RUN) ? remain_q : '0;
  end

endmodule

// File: tb/tb_dispense_timer.sv
// tb_dispense_timer: directed bench for dispense_timer with PRESCALE=2.
// A request-age model predicts t_expired, busy and remaining every cycle;
// directed scenarios also pin pulse latencies to hand-computed numbers.
// Honours DISPENSE_ZERO_SKIP_EN the same way the design does.
module tb_dispense_timer;

  localparam int PRESCALE = 2;
  localparam int DW       = 4;
`ifdef DISPENSE_ZERO_SKIP_EN
  localparam int ZL = 2;
  localparam bit SKIP = 1'b1;
`else
  localparam int ZL = 2 + PRESCALE;
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startTimer = 1'b0;
  logic [2:0]    ingType = 3'd0;
  logic [2:0]    cType = 3'd0;
  logic          tExpired;
  logic          busyO;
  logic [DW-1:0] remainingO;

  int vectors = 0;
  int misses = 0;
  int cycleCnt = 0;

  dispense_timer #(
    .PRESCALE(PRESCALE),
    .DUR_W   (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_timer(startTimer),
    .ing_type   (ingType),
    .c_type     (cType),
    .t_expired  (tExpired),
    .busy       (busyO),
    .remaining  (remainingO)
  );

  // Free-running clock and edge counter used to measure latencies.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Recipe durations, rows = coffee type 1..3, columns = agua..azuc.
  int recipeTbl [3][5] = '{'{3, 4, 0, 0, 1}, '{2, 2, 5, 0, 1}, '{2, 2, 3, 3, 2}};

  function automatic int effDur(input logic [2:0] c, input logic [2:0] ing);
    int d;
    if (ing == 3'd0 || ing > 3'd5) d = 0;
    else if (c >= 3'd1 && c <= 3'd3) d = recipeTbl[int'(c) - 1][int'(ing) - 1];
    else d = 1;
    if (d == 0 && !SKIP) d = 1;
    return d;
  endfunction

  // Model: tracks how many edges old the current request is.
  typedef enum {M_IDLE, M_ACTIVE, M_DONE} mmode_e;
  mmode_e mMode = M_IDLE;
  int     mAge = 0;
  int     mD = 0;
  bit     mPulse = 1'b0;

  // Advance the request model on every clock edge, clear it on reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mMode  = M_IDLE;
      mAge   = 0;
      mD     = 0;
      mPulse = 1'b0;
    end else begin
      mPulse = 1'b0;
      case (mMode)
        M_IDLE: begin
          if (startTimer) begin
            mMode = M_ACTIVE;
            mAge  = 0;
            mD    = effDur(cType, ingType);
          end
        end
        M_ACTIVE: begin
          if (!startTimer) begin
            mMode = M_IDLE;
          end else begin
            mAge = mAge + 1;
            if (mAge == 2 + mD * PRESCALE) begin
              mMode  = M_DONE;
              mPulse = 1'b1;
            end
          end
        end
        default: begin
          if (!startTimer) mMode = M_IDLE;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      misses++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Compare every cycle outside reset against the model's expectations.
  always @(negedge clk) begin
    if (!reset) begin
      int expRem;
      expRem = (mMode == M_ACTIVE && mAge >= 1) ? mD - (mAge - 1) / PRESCALE : 0;
      checkOutput("model_t_expired", int'(tExpired), int'(mPulse));
      checkOutput("model_busy", int'(busyO), (mMode == M_ACTIVE) ? 1 : 0);
      checkOutput("model_remaining", int'(remainingO), expRem);
    end
  end

  task automatic applyStimulus(input logic s, input logic [2:0] ing, input logic [2:0] c);
    @(negedge clk);
    startTimer = s;
    ingType    = ing;
    cType      = c;
  endtask

  // Waits for the pulse; n is the edge that first sampled the request.
  task automatic waitPulse(input int n, input int expLat, input string tag);
    int lat;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tExpired) begin
        lat = cycleCnt - n;
        break;
      end
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busy_done"}, int'(busyO), 0);
    @(negedge clk);
    checkOutput({tag, "_single_pulse"}, int'(tExpired), 0);
  endtask

  task automatic runRequest(input logic [2:0] ing, input logic [2:0] c, input int expLat,
                            input string tag);
    int n;
    applyStimulus(1'b1, ing, c);
    n = cycleCnt + 1;
    waitPulse(n, expLat, tag);
    applyStimulus(1'b0, ing, c);
  endtask

  initial begin
    int n;
    int pulses;
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_t_expired", int'(tExpired), 0);
    checkOutput("reset_busy", int'(busyO), 0);
    checkOutput("reset_remaining", int'(remainingO), 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 3'd0);

    // Single pulse ten edges after request for coffee type 1 cafe (D=4).
    runRequest(3'd2, 3'd1, 10, "ct1_cafe");
    // Zero-duration milk for coffee type 1.
    runRequest(3'd3, 3'd1, ZL, "ct1_milk_zero");

    // Five-phase brew for coffee type 2.
    runRequest(3'd1, 3'd2, 6, "brew_agua");
    runRequest(3'd2, 3'd2, 6, "brew_cafe");
    runRequest(3'd3, 3'd2, 12, "brew_milk");
    runRequest(3'd4, 3'd2, ZL, "brew_choco");
    runRequest(3'd5, 3'd2, 4, "brew_azuc");

    // Other table corners and invalid codes.
    runRequest(3'd5, 3'd3, 6, "ct3_azuc");
    runRequest(3'd4, 3'd6, 4, "ct6_choco");
    runRequest(3'd7, 3'd1, ZL, "invalid_ing7");
    runRequest(3'd0, 3'd3, ZL, "invalid_ing0");

    // Abort: request withdrawn after edge N+3, no pulse afterwards.
    applyStimulus(1'b1, 3'd1, 3'd3);
    n = cycleCnt + 1;
    repeat (4) @(negedge clk);
    checkOutput("abort_remaining_before", int'(remainingO), 1);
    startTimer = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", int'(busyO), 0);
    checkOutput("abort_remaining", int'(remainingO), 0);
    checkOutput("abort_edge", cycleCnt - n, 4);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tExpired) pulses++;
    end
    checkOutput("abort_no_pulse", pulses, 0);

    // Ingredient change during RUN is ignored (agua D=3 kept, not azuc).
    applyStimulus(1'b1, 3'd1, 3'd1);
    n = cycleCnt + 1;
    repeat (3) @(negedge clk);
    ingType = 3'd5;
    waitPulse(n, 8, "ing_change_ignored");
    applyStimulus(1'b0, 3'd0, 3'd0);

    // Asynchronous reset mid-RUN with remaining 2, request held high.
    applyStimulus(1'b1, 3'd1, 3'd1);
    n = cycleCnt + 1;
    repeat (4) @(negedge clk);
    checkOutput("rst_remaining_before", int'(remainingO), 2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_t_expired", int'(tExpired), 0);
    checkOutput("rst_async_busy", int'(busyO), 0);
    checkOutput("rst_async_remaining", int'(remainingO), 0);
    @(negedge clk);
    checkOutput("rst_hold_t_expired", int'(tExpired), 0);
    reset = 1'b0;
    n = cycleCnt + 1;
    @(negedge clk);
    checkOutput("rst_reload_busy", int'(busyO), 1);
    checkOutput("rst_reload_remaining", int'(remainingO), 0);
    waitPulse(n, 8, "rst_rerun");
    applyStimulus(1'b0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
